// File: rtl/cam_core.sv
// Purpose : content-addressable lookup table with indexed write/read and associative search.
// Latency : writes land on the next rising edge; read and search are combinational (0 cycles).
// Backpress: none; a write, read and search are accepted in every cycle.
module cam_core #(
    parameter int DATA_WIDTH = 5,
    parameter int DATA_SIZE  = 1 << DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] read_index,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] write_index,
    input  logic [DATA_SIZE-1:0]  write_data,
    input  logic                  search,
    input  logic [DATA_SIZE-1:0]  search_data,
    output logic [DATA_SIZE-1:0]  read_value,
    output logic                  read_valid,
    output logic [DATA_WIDTH-1:0] search_index,
    output logic                  search_valid
);

    localparam int ENTRIES = 1 << DATA_WIDTH;

    logic [DATA_SIZE-1:0] mem_q [ENTRIES];
    logic [DATA_SIZE-1:0] mem_d [ENTRIES];
    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   valid_d;
    logic [ENTRIES-1:0]   match;

    // Next-state: an accepted write overwrites one slot and marks it valid.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (write) begin
            mem_d[write_index]   = write_data;
            valid_d[write_index] = 1'b1;
        end
    end

    // State register; reset clears every slot and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    // Indexed read: only a valid slot returns data, otherwise zeros.
    always_comb begin
        read_valid = read && valid_q[read_index];
        read_value = read_valid ? mem_q[read_index] : '0;
    end

    // Per-slot full-width compare; invalid slots can never match.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid_q[i] && (mem_q[i] == search_data);
        end
    end

    // Priority encoder: scan from the top so the lowest matching slot wins.
    always_comb begin
        search_index = '1;
        search_valid = 1'b0;
        if (search) begin
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (match[i]) begin
                    search_index = i[DATA_WIDTH-1:0];
                    search_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_core.sv
// Bench for cam_core: directed scenarios then random traffic against a behavioural table model.
module tb_cam_core;

    localparam int DW = 5;
    localparam int DS = 32;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          read;
    logic [DW-1:0] read_index;
    logic          write;
    logic [DW-1:0] write_index;
    logic [DS-1:0] write_data;
    logic          search;
    logic [DS-1:0] search_data;
    logic [DS-1:0] read_value;
    logic          read_valid;
    logic [DW-1:0] search_index;
    logic          search_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: plain table of contents plus a valid flag per slot.
    logic [DS-1:0] ref_mem [N];
    bit            ref_vld [N];
    logic [DS-1:0] pool [4];

    cam_core #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
        .clk          (clk),
        .rst          (rst),
        .read         (read),
        .read_index   (read_index),
        .write        (write),
        .write_index  (write_index),
        .write_data   (write_data),
        .search       (search),
        .search_data  (search_data),
        .read_value   (read_value),
        .read_valid   (read_valid),
        .search_index (search_index),
        .search_valid (search_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all four outputs against what the model predicts for the current inputs.
    task automatic check_all(input string tag);
        logic [DS-1:0] e_rv;
        logic          e_rvld;
        logic [DW-1:0] e_si;
        logic          e_svld;
        #1;
        e_rvld = read && ref_vld[read_index];
        e_rv   = e_rvld ? ref_mem[read_index] : '0;
        e_si   = '1;
        e_svld = 1'b0;
        if (search) begin
            for (int i = 0; i < N; i++) begin
                if (!e_svld && ref_vld[i] && ref_mem[i] == search_data) begin
                    e_si   = DW'(i);
                    e_svld = 1'b1;
                end
            end
        end
        chk({tag, ".read_value"},   read_value,          e_rv);
        chk({tag, ".read_valid"},   DS'(read_valid),     DS'(e_rvld));
        chk({tag, ".search_index"}, DS'(search_index),   DS'(e_si));
        chk({tag, ".search_valid"}, DS'(search_valid),   DS'(e_svld));
    endtask

    // Advance one rising edge, applying the table rules to the model.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ref_mem[i] = '0;
                ref_vld[i] = 1'b0;
            end
        end else if (write) begin
            ref_mem[write_index] = write_data;
            ref_vld[write_index] = 1'b1;
        end
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] idx, input logic [DS-1:0] dat);
        write       = 1'b1;
        write_index = idx;
        write_data  = dat;
        step();
        write = 1'b0;
    endtask

    task automatic probe(input logic [DW-1:0] ridx, input logic [DS-1:0] key);
        read        = 1'b1;
        read_index  = ridx;
        search      = 1'b1;
        search_data = key;
    endtask

    initial begin
        pool[0] = 32'h0000_0000;
        pool[1] = 32'h0000_0005;
        pool[2] = 32'h0000_0007;
        pool[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = '0;
            ref_vld[i] = 1'b0;
        end
        rst = 1'b1; read = 1'b0; read_index = '0; write = 1'b0; write_index = '0;
        write_data = '0; search = 1'b0; search_data = '0;
        step();
        rst = 1'b0;

        // Post-reset idle outputs.
        check_all("reset_idle");
        chk("reset_idle.search_index_const", DS'(search_index), 32'd31);

        // Read of an unwritten slot after reset.
        read = 1'b1; read_index = 5'd9;
        check_all("reset_read9");
        chk("reset_read9.valid_const", DS'(read_valid), 32'd0);

        // Search for 0 over all-zero but invalid contents.
        search = 1'b1; search_data = '0;
        check_all("reset_search0");
        chk("reset_search0.valid_const", DS'(search_valid), 32'd0);

        // Write 7 to 9, visible right after the edge.
        wr(5'd9, 32'd7);
        probe(5'd9, 32'd7);
        check_all("wr9_probe");
        chk("wr9_probe.search_index_const", DS'(search_index), 32'd9);
        chk("wr9_probe.read_value_const", read_value, 32'd7);

        // Search disabled while a match exists.
        search = 1'b0;
        check_all("search_disabled");

        // Duplicates: lowest index wins, overwrite moves the hit.
        wr(5'd20, 32'd5);
        wr(5'd3, 32'd5);
        probe(5'd3, 32'd5);
        check_all("dup_lowest");
        chk("dup_lowest.idx_const", DS'(search_index), 32'd3);
        wr(5'd3, 32'd6);
        probe(5'd3, 32'd5);
        check_all("overwrite_moves");
        chk("overwrite_moves.idx_const", DS'(search_index), 32'd20);

        // Zero stored in the top slot becomes a real hit at index 31.
        wr(5'd31, 32'd0);
        probe(5'd31, 32'd0);
        check_all("zero_at_31");
        chk("zero_at_31.valid_const", DS'(search_valid), 32'd1);

        // Same-cycle write and probe: pre-edge contents until the edge.
        write = 1'b1; write_index = 5'd12; write_data = 32'h1234_5678;
        probe(5'd12, 32'h1234_5678);
        check_all("same_cycle_pre");
        step();
        write = 1'b0;
        check_all("same_cycle_post");

        // Reset beats a simultaneous write.
        rst = 1'b1; write = 1'b1; write_index = 5'd4; write_data = 32'hDEAD_BEEF;
        step();
        rst = 1'b0; write = 1'b0;
        probe(5'd4, 32'hDEAD_BEEF);
        check_all("rst_beats_write");
        chk("rst_beats_write.rvld_const", DS'(read_valid), 32'd0);

        // Full-width compare: one differing bit misses.
        wr(5'd0, 32'hFFFF_FFFF);
        probe(5'd0, 32'hFFFF_FFFE);
        check_all("full_width");
        chk("full_width.idx_const", DS'(search_index), 32'd31);

        // Random traffic with a small data pool to force hits and duplicates.
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 39) == 0);
            write       = ($urandom_range(0, 1) == 1);
            write_index = DW'($urandom_range(0, N - 1));
            write_data  = ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 3)];
            read        = ($urandom_range(0, 3) != 0);
            read_index  = DW'($urandom_range(0, N - 1));
            search      = ($urandom_range(0, 3) != 0);
            search_data = pool[$urandom_range(0, 3)];
            check_all("rand");
            step();
        end
        rst = 1'b0; write = 1'b0;
        check_all("rand_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
